// File: rtl/bus_pkg.sv
// Shared definitions for the physical bus bridges.
//   - state_t         : bridge FSM state encoding
//   - region_t        : decoded physical region (RAM / IO / unmapped)
//   - IO_BASE_DEFAULT : upper 16 address bits of the 64 KiB confreg window
package bus_pkg;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'h1FAF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_WAIT,
    S_IO_WAIT,
    S_ERR,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_ERR
  } region_t;

endpackage

// File: rtl/phys_region_decode.sv
// Combinational physical-address region decoder.
// Only the upper half-word is needed to pick a region, so only that is passed.
//   i_addr_hi : cpu address bits [31:16]
//   o_region  : REGION_IO for the confreg window, REGION_RAM for the low
//               512 MiB (outside the IO window), REGION_ERR otherwise
module phys_region_decode
  import bus_pkg::*;
#(
  parameter logic [15:0] IO_BASE = IO_BASE_DEFAULT
)(
  input  logic [15:0] i_addr_hi,
  output region_t     o_region
);

  // IO is checked first so the window wins even if it is moved below 512 MiB.
  always_comb begin
    o_region = REGION_ERR;
    if (i_addr_hi == IO_BASE)
      o_region = REGION_IO;
    else if (i_addr_hi[15:13] == 3'b000)
      o_region = REGION_RAM;
  end

endmodule

// File: rtl/phys_bus_bridge.sv
// Physical bus bridge: accepts one CPU request at a time, decodes the region,
// forwards the latched request to RAM or IO and returns a one-cycle ack with
// read data or a bus error.
// Ports:
//   clk, rst              : clock, async active-high reset
//   cpu_*                 : CPU-side request (req held until ack) / response
//   ram_* , io_*          : slave request (fields driven only while req) and
//                           ready/rdata completion
// Optional build macro BUS_TIMEOUT_EN: a wait state that sees no ready for
// TIMEOUT_CYCLES cycles is terminated with cpu_err = 1.
module phys_bus_bridge
  import bus_pkg::*;
#(
  parameter logic [15:0] IO_BASE        = IO_BASE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 16
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sel,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_sel,
  input  logic        io_ready,
  input  logic [31:0] io_rdata
);

  state_t      r_state, w_state_nxt;
  region_t     w_region;
  logic        r_we, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_sel;
  logic        w_ram_wait, w_io_wait, w_ready, w_timeout;
  logic [31:0] w_slave_rdata;

  phys_region_decode #(.IO_BASE(IO_BASE)) u_decode (
    .i_addr_hi (cpu_addr[31:16]),
    .o_region  (w_region)
  );

  assign w_ram_wait    = (r_state == S_RAM_WAIT);
  assign w_io_wait     = (r_state == S_IO_WAIT);
  // Ready only counts from the slave we are actually waiting on.
  assign w_ready       = (w_ram_wait & ram_ready) | (w_io_wait & io_ready);
  assign w_slave_rdata = w_ram_wait ? ram_rdata : io_rdata;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;

  // Wait states are only entered from IDLE, so holding the count at zero
  // outside them clears it on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (!(w_ram_wait || w_io_wait))
      r_cnt <= '0;
    else if (!w_ready && !w_timeout)
      r_cnt <= r_cnt + 1'b1;
  end

  // Ready on the limit cycle takes priority via the ~w_ready term.
  assign w_timeout = (w_ram_wait | w_io_wait) & ~w_ready &
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          unique case (w_region)
            REGION_RAM: w_state_nxt = S_RAM_WAIT;
            REGION_IO:  w_state_nxt = S_IO_WAIT;
            default:    w_state_nxt = S_ERR;
          endcase
        end
      end
      S_RAM_WAIT, S_IO_WAIT: if (w_ready || w_timeout) w_state_nxt = S_RESP;
      S_ERR:   w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch and response capture. Response regs are cleared in RESP so
  // cpu_rdata/cpu_err fall together with ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_sel   <= cpu_sel;
          end
        end
        S_RAM_WAIT, S_IO_WAIT: begin
          if (w_ready) begin
            r_rdata <= r_we ? '0 : w_slave_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        S_ERR: begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
        default: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack   = (r_state == S_RESP);
  assign cpu_rdata = r_rdata;
  assign cpu_err   = r_err;

  // Slave fields are zero whenever that slave is not being requested.
  assign ram_req   = w_ram_wait;
  assign ram_we    = w_ram_wait & r_we;
  assign ram_addr  = w_ram_wait ? r_addr  : '0;
  assign ram_wdata = w_ram_wait ? r_wdata : '0;
  assign ram_sel   = w_ram_wait ? r_sel   : '0;

  assign io_req    = w_io_wait;
  assign io_we     = w_io_wait & r_we;
  assign io_addr   = w_io_wait ? r_addr  : '0;
  assign io_wdata  = w_io_wait ? r_wdata : '0;
  assign io_sel    = w_io_wait ? r_sel   : '0;

endmodule

// File: doc/phys_bus_bridge.md
Name: phys_bus_bridge

Overview:
- Responder for physical addresses produced by address translation; sits between the CPU data/instruction port and the memory/peripheral slaves.
- Accepts one request at a time from the CPU side and decodes the physical region: RAM, IO (confreg window) or unmapped.
- Forwards the request to the selected slave and holds it until the slave reports ready, then returns a single-cycle acknowledge with read data or a bus error.

Parameters:
- IO_BASE, 16'h1FAF, upper 16 bits of the 64 KiB peripheral window.
- TIMEOUT_CYCLES, 16, slave wait limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- cpu_req  input  1  request valid; held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  32  physical byte address
- cpu_wdata  input  32  write data
- cpu_sel  input  4  byte enables
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  32  read data, valid with cpu_ack
- cpu_err  output  1  bus error, valid with cpu_ack
- ram_req / io_req  output  1  slave request
- ram_we / io_we  output  1  slave write enable
- ram_addr / io_addr  output  32  latched physical address, passed unchanged
- ram_wdata / io_wdata  output  32  latched write data
- ram_sel / io_sel  output  4  latched byte enables
- ram_ready / io_ready  input  1  slave completion
- ram_rdata / io_rdata  input  32  slave read data, valid with ready

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: FSM in IDLE. All outputs are 0: cpu_ack, cpu_err, cpu_rdata, every *_req, *_we, *_addr, *_wdata and *_sel.
- Decode, priority order:
  - IO when cpu_addr[31:16] == IO_BASE.
  - RAM when cpu_addr[31:29] == 3'b000 and the address is not IO.
  - Otherwise ERR.
- FSM states: IDLE, RAM_WAIT, IO_WAIT, ERR, RESP.
- IDLE:
  - When cpu_req = 1, latch we, addr, wdata and sel.
  - Go to RAM_WAIT, IO_WAIT or ERR according to the decode.
- RAM_WAIT / IO_WAIT:
  - The matching *_req is 1 and the latched fields drive the slave. The other slave's req is 0.
  - On ready = 1, capture rdata (writes capture 0), drop req on the next edge and go to RESP.
  - Ready seen in the first cycle of the wait state is legal.
- ERR: go to RESP with the error flag set and rdata = 0. No slave is touched.
- RESP:
  - cpu_ack = 1 for exactly one cycle; cpu_rdata and cpu_err are valid.
  - Then return to IDLE. cpu_err and cpu_rdata clear to 0 when ack falls.
- Latency: request sampled at edge T; slave req is high during T+1; if ready arrives that cycle, cpu_ack is high during T+2. Minimum latency is 2 cycles; ERR also completes in 2 cycles.
- Busy: while not in IDLE, changes on cpu_* are ignored. A new request is accepted no earlier than the cycle after ack, in IDLE.
- Back-to-back: when cpu_req stays high after ack, it is treated as a new request in the following IDLE cycle.
- Ready while idle: ready outside the matching wait state is ignored.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. No ack is ever produced for the aborted request.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to a wait state and increments each cycle that ready = 0.
  - When the count reaches TIMEOUT_CYCLES-1 without ready, the bridge drops req and goes to RESP with cpu_err = 1 and rdata = 0.
  - Ready in the same cycle as the limit wins: normal completion.
- Undefined: no counter; wait states last until ready.

Decomposition:
- Package bus_pkg: FSM state encoding, region codes (REGION_RAM, REGION_IO, REGION_ERR) and the IO_BASE default.
- Sub-module phys_region_decode: combinational address-to-region decoder, reusable by the instruction-side bridge.

Test Plan:
- Read RAM 0x0000_1000; ram_ready asserted in the first wait cycle with rdata 0xDEADBEEF -> ram_req high 1 cycle, cpu_ack 2 cycles after request, cpu_rdata = 0xDEADBEEF, cpu_err = 0.
- Write IO 0x1FAF_F000, wdata 0x0000_00FF, sel 4'b0001; io_ready delayed 3 cycles -> io_req high 4 cycles with latched fields, ram_req stays 0, single ack, cpu_err = 0.
- Read 0x4000_0000 -> no slave req, ack 2 cycles after request, cpu_err = 1, cpu_rdata = 0.
- Two back-to-back RAM reads at 0x10 then 0x14 with cpu_req held high -> two separate acks, second ram_addr = 0x14, one IDLE cycle between.
- Assert rst during RAM_WAIT -> ram_req and all outputs 0 immediately; no ack after release; next request served normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 16, ram_ready held 0 -> req drops after 16 wait cycles, ack with cpu_err = 1.
